audio_codec_serializer: RTL and testbench

AUDIO_CODEC_SERIALIZER -- requirements
Module: audio_codec_serializer

---
 rtl/audio_codec_serializer.sv | 140 ++++++++++++++
 tb/tb_audio_codec_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_serializer.sv
// ============================================================================
// Module  : audio_codec_serializer
// Brief   : I2S-style codec frame master: 32-slot frames, one 16-bit DAC
//           sample mirrored on both channels, left-channel ADC capture.
//           Optional macro AUDIO_ADC_CAPTURE_EN enables the ADC capture path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_codec_serializer #(
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] dac_sample,
  output logic        sample_req,
  output logic        sample_end,
  output logic [15:0] adc_sample,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_ADCLRCK,
  output logic        AUD_DACDAT,
  input  logic        AUD_ADCDAT
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_PRIME = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;
  localparam logic [7:0] c_DIV_LAST = 8'(BCLK_HALF - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [7:0]  r_div;
  logic        r_half;
  logic [4:0]  r_slot;
  logic        r_stop;
  logic [15:0] r_hold;
  logic        r_sample_end;

  logic w_active;
  logic w_first;
  logic w_slot_end;
  logic w_frame_end;
  logic w_capture;

  assign w_active    = (r_state != c_ST_IDLE);
  assign w_first     = w_active && (r_div == 8'd0) && !r_half;
  assign w_slot_end  = w_active && (r_div == c_DIV_LAST) && r_half;
  assign w_frame_end = w_slot_end && (r_slot == 5'd31);
  // ADC bit is taken on the first clk of the BCLK-high half, left slots only
  assign w_capture   = (r_state == c_ST_RUN) && r_half && (r_div == 8'd0) && !r_slot[4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (enable) w_state_next = c_ST_PRIME;
      c_ST_PRIME: if (w_slot_end) w_state_next = c_ST_RUN;
      c_ST_RUN:   if (w_frame_end && r_stop) w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // PRIME is entered as slot 31 so the natural wrap lands on RUN slot 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= 8'd0;
      r_half <= 1'b0;
      r_slot <= 5'd0;
    end else if (r_state == c_ST_IDLE) begin
      r_div  <= 8'd0;
      r_half <= 1'b0;
      r_slot <= (w_state_next == c_ST_PRIME) ? 5'd31 : 5'd0;
    end else if (w_state_next == c_ST_IDLE) begin
      r_div  <= 8'd0;
      r_half <= 1'b0;
      r_slot <= 5'd0;
    end else if (r_div == c_DIV_LAST) begin
      r_div  <= 8'd0;
      r_half <= ~r_half;
      if (r_half) r_slot <= r_slot + 5'd1;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stop       <= 1'b0;
      r_hold       <= 16'd0;
      r_sample_end <= 1'b0;
    end else begin
      if (r_state != c_ST_RUN)
        r_stop <= 1'b0;
      else if (w_first && (r_slot == 5'd31))
        r_stop <= ~enable;
      if (w_frame_end && (w_state_next == c_ST_RUN))
        r_hold <= dac_sample;
      r_sample_end <= w_capture && (r_slot[3:0] == 4'hF);
    end
  end

`ifdef AUDIO_ADC_CAPTURE_EN
  logic [14:0] r_shift;
  logic [15:0] r_adc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 15'd0;
      r_adc   <= 16'd0;
    end else if (w_capture) begin
      if (r_slot[3:0] == 4'hF) r_adc <= {r_shift, AUD_ADCDAT};
      else                     r_shift <= {r_shift[13:0], AUD_ADCDAT};
    end
  end

  assign adc_sample = r_adc;
`else
  logic w_unused_adcdat;
  assign w_unused_adcdat = AUD_ADCDAT;
  assign adc_sample      = 16'd0;
`endif

  always_comb begin
    sample_req  = w_first && (r_slot == 5'd31) && enable;
    sample_end  = r_sample_end;
    AUD_BCLK    = w_active && r_half;
    AUD_DACLRCK = (r_state == c_ST_RUN) && !r_slot[4];
    AUD_ADCLRCK = (r_state == c_ST_RUN) && !r_slot[4];
    AUD_DACDAT  = (r_state == c_ST_RUN) ? r_hold[~r_slot[3:0]] : 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_codec_serializer.sv
// ============================================================================
// Module  : tb_audio_codec_serializer
// Brief   : Directed self-checking bench for audio_codec_serializer (BCLK_HALF=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_codec_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] dac_sample;
  logic        AUD_ADCDAT;
  logic        sample_req;
  logic        sample_end;
  logic [15:0] adc_sample;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_ADCLRCK;
  logic        AUD_DACDAT;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef AUDIO_ADC_CAPTURE_EN
  localparam bit c_CAP = 1'b1;
`else
  localparam bit c_CAP = 1'b0;
`endif

  audio_codec_serializer #(.BCLK_HALF(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dac_sample  (dac_sample),
    .sample_req  (sample_req),
    .sample_end  (sample_end),
    .adc_sample  (adc_sample),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .AUD_ADCDAT  (AUD_ADCDAT)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset      = 1'b1;
    enable     = 1'b0;
    dac_sample = 16'h0000;
    AUD_ADCDAT = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_outputs got %b want 000000",
               {sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT});
    end
    n_checks++;
    if (adc_sample !== 16'h0000) begin
      n_fails++;
      $display("FAIL reset_adc_sample got %h want 0000", adc_sample);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT} !== 6'b0) begin
        n_fails++;
        $display("FAIL idle_disabled got %b want 000000",
                 {sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT});
      end
    end
  endtask

  // Enable from IDLE and walk the 8-clk PRIME slot; upstream answers sample_req a clk later.
  task automatic test_prime(input logic [15:0] next_dac);
    logic exp_bclk;
    logic exp_req;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_req  = (k == 0);
      exp_bclk = (k >= 4);
      n_checks++;
      if (sample_req !== exp_req) begin
        n_fails++;
        $display("FAIL prime_req k=%0d got %b want %b", k, sample_req, exp_req);
      end
      n_checks++;
      if (AUD_BCLK !== exp_bclk) begin
        n_fails++;
        $display("FAIL prime_bclk k=%0d got %b want %b", k, AUD_BCLK, exp_bclk);
      end
      n_checks++;
      if ({AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT, sample_end} !== 4'b0000) begin
        n_fails++;
        $display("FAIL prime_lrck_dat k=%0d got %b want 0000", k,
                 {AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT, sample_end});
      end
      if (k == 1) dac_sample = next_dac;
    end
  endtask

  task automatic test_run_frame(input logic [15:0] exp_dac, input logic [15:0] adc_left,
                                input logic [15:0] adc_right, input logic [15:0] next_dac,
                                input int drop_slot);
    logic        exp_bclk, exp_lr, exp_dat, exp_req, exp_end;
    logic [15:0] exp_adc;
    exp_adc = c_CAP ? adc_left : 16'h0000;
    for (int s = 0; s < 32; s++) begin
      for (int off = 0; off < 8; off++) begin
        @(negedge clk);
        exp_bclk = (off >= 4);
        exp_lr   = (s < 16);
        exp_dat  = exp_dac[15 - (s % 16)];
        exp_req  = (s == 31) && (off == 0) && enable;
        exp_end  = (s == 15) && (off == 5);
        n_checks++;
        if (AUD_BCLK !== exp_bclk) begin
          n_fails++;
          $display("FAIL run_bclk slot=%0d off=%0d got %b want %b", s, off, AUD_BCLK, exp_bclk);
        end
        n_checks++;
        if ({AUD_DACLRCK, AUD_ADCLRCK} !== {exp_lr, exp_lr}) begin
          n_fails++;
          $display("FAIL run_lrck slot=%0d off=%0d got %b%b want %b", s, off,
                   AUD_DACLRCK, AUD_ADCLRCK, exp_lr);
        end
        n_checks++;
        if (AUD_DACDAT !== exp_dat) begin
          n_fails++;
          $display("FAIL run_dacdat slot=%0d off=%0d got %b want %b", s, off, AUD_DACDAT, exp_dat);
        end
        n_checks++;
        if (sample_req !== exp_req) begin
          n_fails++;
          $display("FAIL run_sample_req slot=%0d off=%0d got %b want %b", s, off, sample_req, exp_req);
        end
        n_checks++;
        if (sample_end !== exp_end) begin
          n_fails++;
          $display("FAIL run_sample_end slot=%0d off=%0d got %b want %b", s, off, sample_end, exp_end);
        end
        if (exp_end) begin
          n_checks++;
          if (adc_sample !== exp_adc) begin
            n_fails++;
            $display("FAIL run_adc_sample got %h want %h", adc_sample, exp_adc);
          end
        end
        if (off == 0) AUD_ADCDAT = (s < 16) ? adc_left[15 - s] : adc_right[31 - s];
        if ((s == drop_slot) && (off == 0)) enable = 1'b0;
        if ((s == 31) && (off == 1) && enable) dac_sample = next_dac;
      end
    end
  endtask

  task automatic test_idle_after_stop;
    repeat (12) begin
      @(negedge clk);
      n_checks++;
      if ({sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT} !== 6'b0) begin
        n_fails++;
        $display("FAIL stop_idle got %b want 000000",
                 {sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT});
      end
    end
  endtask

  // Run into slot 20 (BCLK high, DACDAT=1 from an all-ones hold), then reset between edges.
  task automatic test_reset_midframe;
    dac_sample = 16'hFFFF;
    enable     = 1'b1;
    repeat (174) @(negedge clk);
    n_checks++;
    if ({AUD_BCLK, AUD_DACDAT, AUD_DACLRCK} !== 3'b110) begin
      n_fails++;
      $display("FAIL midframe_pre got %b want 110", {AUD_BCLK, AUD_DACDAT, AUD_DACLRCK});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT} !== 6'b0) begin
      n_fails++;
      $display("FAIL midframe_async_reset got %b want 000000",
               {sample_req, sample_end, AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT});
    end
    n_checks++;
    if (adc_sample !== 16'h0000) begin
      n_fails++;
      $display("FAIL midframe_adc_reset got %h want 0000", adc_sample);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_prime(16'h0F0F);
    @(negedge clk);
    n_checks++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT} !== 4'b0110) begin
      n_fails++;
      $display("FAIL restart_slot0 got %b want 0110",
               {AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT});
    end
  endtask

  initial begin
    test_reset();
    test_prime(16'hA5C3);
    test_run_frame(16'hA5C3, 16'h7FFE, 16'hFFFF, 16'h8001, -1);
    test_run_frame(16'h8001, 16'h8001, 16'h0000, 16'h0000, 5);
    test_idle_after_stop();
    test_reset_midframe();
    reset = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
